// File: rtl/ahb_rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_rr_burst_arbiter
//
// Address-phase arbiter for a two-input AHB output stage that feeds one
// bus-matrix slave port. It chooses which input port (0 or 1) drives the
// shared slave address phase. Selection is round-robin, or fixed priority with
// port 0 highest. The grant is held across fixed-length bursts, undefined-length
// (INCR) bursts and locked sequences.
//
// Every decision is registered and advances only on HREADYM-high edges. As a
// result, addr_in_port and no_port stay stable through slave wait states.
//
// Parameters
//   INCR_LIMIT   max beats an INCR burst may keep the grant, 0 = unlimited
//                (0..255)
//   RR_ENABLE    1 = round-robin, 0 = fixed priority (port 0 highest)
//
// Ports
//   HCLK          in   AHB system clock
//   HRESETn       in   asynchronous active-low reset
//   req_port0     in   port 0 request (transfer pending with HSEL to this slave)
//   req_port1     in   port 1 request
//   HREADYM       in   HREADYMUX from the output stage; state advances when high
//   HSELM         in   muxed HSEL of the currently granted port
//   HTRANSM[1:0]  in   muxed HTRANS of the granted port
//   HBURSTM[2:0]  in   muxed HBURST of the granted port
//   HMASTLOCKM    in   muxed HMASTLOCK, already masked by HSEL/lock state
//   addr_in_port  out  granted port number (registered)
//   no_port       out  1 = no port granted, output stage drives idle (registered)
// -----------------------------------------------------------------------------
module ahb_rr_burst_arbiter #(
  parameter int unsigned INCR_LIMIT = 0,
  parameter bit          RR_ENABLE  = 1'b1
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       req_port0,
  input  logic       req_port1,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  input  logic       HMASTLOCKM,
  output logic       addr_in_port,
  output logic       no_port
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [7:0] INCR_LIMIT_C = 8'(INCR_LIMIT);
  localparam bit         LIMIT_ON     = (INCR_LIMIT != 0);

  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
    ST_LOCKED    = 2'd1,
    ST_FIXBURST  = 2'd2,
    ST_INCRBURST = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        addr_q, addr_d;
  logic        no_port_q, no_port_d;
  logic [3:0]  beat_q, beat_d;
  logic [7:0]  incr_q, incr_d;

  logic        lock_seen_s;
  logic        start_s;
  logic [4:0]  burst_len_s;
  logic [7:0]  incr_step_s;
  logic        do_arb_s;
  logic [1:0]  pick_s;

  // Beat count of a burst type; 0 marks INCR (undefined length).
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    logic [4:0] len;
    case (hburst)
      3'b000:         len = 5'd1;
      3'b001:         len = 5'd0;
      3'b010, 3'b011: len = 5'd4;
      3'b100, 3'b101: len = 5'd8;
      3'b110, 3'b111: len = 5'd16;
      default:        len = 5'd1;
    endcase
    return len;
  endfunction

  // Arbitration result {none, port}. The last granted port has the lowest
  // priority. With no request the grant parks on the last port.
  function automatic logic [1:0] rr_pick(input logic r0, input logic r1,
                                         input logic last);
    logic [1:0] res;
    if (r0 && r1) begin
      res = {1'b0, (RR_ENABLE ? ~last : 1'b0)};
    end else if (r0) begin
      res = 2'b00;
    end else if (r1) begin
      res = 2'b01;
    end else begin
      res = {1'b1, last};
    end
    return res;
  endfunction

  // The muxed control inputs only mean something while a port is granted.
  assign lock_seen_s = HMASTLOCKM & ~no_port_q;
  assign start_s     = ~no_port_q & HSELM & (HTRANSM == TRANS_NONSEQ);
  assign burst_len_s = burst_len(HBURSTM);
  assign pick_s      = rr_pick(req_port0, req_port1, addr_q);

  // Next-state decision: hold states first, then round-robin arbitration.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    no_port_d   = no_port_q;
    beat_d      = beat_q;
    incr_d      = incr_q;
    do_arb_s    = 1'b0;
    incr_step_s = incr_q;

    if (!HREADYM) begin
      // Wait state: every register keeps its value.
      state_d = state_q;
    end else if (lock_seen_s) begin
      // Lock overrides any burst counting; the grant stays where it is.
      state_d   = ST_LOCKED;
      no_port_d = 1'b0;
      beat_d    = 4'd0;
      incr_d    = 8'd0;
    end else begin
      case (state_q)
        ST_FIXBURST: begin
          if (HSELM && (HTRANSM == TRANS_SEQ)) begin
            if (beat_q > 4'd1) begin
              beat_d = beat_q - 4'd1;
            end else begin
              beat_d   = 4'd0;
              do_arb_s = 1'b1;
            end
          end else if (HSELM && (HTRANSM == TRANS_BUSY)) begin
            beat_d = beat_q;
          end else begin
            // IDLE, NONSEQ or deselect ends the burst early.
            beat_d   = 4'd0;
            do_arb_s = 1'b1;
          end
        end
        ST_INCRBURST: begin
          if (HSELM && ((HTRANSM == TRANS_SEQ) || (HTRANSM == TRANS_BUSY))) begin
            if ((HTRANSM == TRANS_SEQ) && (incr_q != 8'hFF)) begin
              incr_step_s = incr_q + 8'd1;
            end else begin
              incr_step_s = incr_q;
            end
            incr_d = incr_step_s;
            if (LIMIT_ON && (incr_step_s >= INCR_LIMIT_C)) begin
              do_arb_s = 1'b1;
            end else begin
              state_d = ST_INCRBURST;
            end
          end else begin
            do_arb_s = 1'b1;
          end
        end
        ST_ARB: begin
          if (start_s && (burst_len_s > 5'd1)) begin
            state_d = ST_FIXBURST;
            beat_d  = 4'(burst_len_s - 5'd1);
          end else if (start_s && (burst_len_s == 5'd0)) begin
            incr_d = 8'd1;
            // A limit of 1 grants the NONSEQ beat alone.
            if (LIMIT_ON && (8'd1 >= INCR_LIMIT_C)) begin
              do_arb_s = 1'b1;
            end else begin
              state_d = ST_INCRBURST;
            end
          end else begin
            do_arb_s = 1'b1;
          end
        end
        default: begin
          // ST_LOCKED with the lock released: arbitrate on this same edge.
          do_arb_s = 1'b1;
        end
      endcase
    end

    if (do_arb_s) begin
      state_d   = ST_ARB;
      beat_d    = 4'd0;
      incr_d    = 8'd0;
      no_port_d = pick_s[1];
      addr_d    = pick_s[0];
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers; reset takes effect immediately, even mid-burst.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_ARB;
      addr_q    <= 1'b0;
      no_port_q <= 1'b1;
      beat_q    <= 4'd0;
      incr_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      no_port_q <= no_port_d;
      beat_q    <= beat_d;
      incr_q    <= incr_d;
    end
  end

  assign addr_in_port = addr_q;
  assign no_port      = no_port_q;

endmodule

// File: tb/tb_ahb_rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for ahb_rr_burst_arbiter. Three instances share the same stimulus:
//   A: defaults (round-robin, unlimited INCR)
//   B: INCR_LIMIT = 4
//   C: RR_ENABLE = 0 (fixed priority)
// Each vector is applied for one clock. The expected outputs of all three
// instances are checked just after the following rising edge.
// -----------------------------------------------------------------------------
module tb_ahb_rr_burst_arbiter;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] BSY = 2'b01;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;
  localparam logic [2:0] SGL = 3'b000;
  localparam logic [2:0] INC = 3'b001;
  localparam logic [2:0] W4  = 3'b010;
  localparam logic [2:0] I8  = 3'b101;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b1;
  logic       req_port0 = 1'b0;
  logic       req_port1 = 1'b0;
  logic       HREADYM = 1'b1;
  logic       HSELM = 1'b0;
  logic [1:0] HTRANSM = 2'b00;
  logic [2:0] HBURSTM = 3'b000;
  logic       HMASTLOCKM = 1'b0;
  logic       addr_a, no_a, addr_b, no_b, addr_c, no_c;

  int n_checks = 0;
  int n_fail   = 0;

  // exp = {addrA, noA, addrB, noB, addrC, noC}
  typedef struct packed {
    logic       rst;
    logic       r0;
    logic       r1;
    logic       rdy;
    logic       sel;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       lk;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [64];
  int   n_vec = 0;

  always #5 HCLK = ~HCLK;

  ahb_rr_burst_arbiter u_dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_port0(req_port0), .req_port1(req_port1),
    .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM),
    .HMASTLOCKM(HMASTLOCKM), .addr_in_port(addr_a), .no_port(no_a)
  );

  ahb_rr_burst_arbiter #(.INCR_LIMIT(4)) u_dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_port0(req_port0), .req_port1(req_port1),
    .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM),
    .HMASTLOCKM(HMASTLOCKM), .addr_in_port(addr_b), .no_port(no_b)
  );

  ahb_rr_burst_arbiter #(.RR_ENABLE(1'b0)) u_dut_c (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_port0(req_port0), .req_port1(req_port1),
    .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM),
    .HMASTLOCKM(HMASTLOCKM), .addr_in_port(addr_c), .no_port(no_c)
  );

  task automatic add(input logic rst, input logic r0, input logic r1,
                     input logic rdy, input logic sel, input logic [1:0] tr,
                     input logic [2:0] bu, input logic lk, input logic [5:0] ex);
    tbl[n_vec] = {rst, r0, r1, rdy, sel, tr, bu, lk, ex};
    n_vec++;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0b required %0b", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [5:0] ex);
    chk({tag, " A.addr"}, addr_a, ex[5]);
    chk({tag, " A.no_port"}, no_a, ex[4]);
    chk({tag, " B.addr"}, addr_b, ex[3]);
    chk({tag, " B.no_port"}, no_b, ex[2]);
    chk({tag, " C.addr"}, addr_c, ex[1]);
    chk({tag, " C.no_port"}, no_c, ex[0]);
  endtask

  task automatic drive_idle();
    req_port0 = 1'b0; req_port1 = 1'b0; HREADYM = 1'b1; HSELM = 1'b0;
    HTRANSM = IDL; HBURSTM = SGL; HMASTLOCKM = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge HCLK);
    drive_idle();
    HRESETn = 1'b0;
    #2;
    check_all(tag, 6'b01_01_01);
    @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
  endtask

  initial begin
    // S1: reset, single request, park with no requests
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, IDL, SGL, 1'b0, 6'b01_01_01);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, IDL, SGL, 1'b0, 6'b10_10_10);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, IDL, SGL, 1'b0, 6'b11_11_11);
    // S2: both requesting SINGLE transfers, one wait state on a decision edge
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, NSQ, SGL, 1'b0, 6'b10_10_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NSQ, SGL, 1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, NSQ, SGL, 1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NSQ, SGL, 1'b0, 6'b10_10_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NSQ, SGL, 1'b0, 6'b00_00_00);
    // S3: port 0 INCR8 with a BUSY and two wait states, port 1 requesting
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, IDL, SGL, 1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NSQ, I8,  1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, SQ,  I8,  1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, BSY, I8,  1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, SQ,  I8,  1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, SQ,  I8,  1'b0, 6'b00_00_00);
    for (int k = 0; k < 5; k++) begin
      add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, SQ, I8, 1'b0, 6'b00_00_00);
    end
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, SQ,  I8,  1'b0, 6'b10_10_00);
    // S4: WRAP4 ended by IDLE after two beats
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, IDL, SGL, 1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NSQ, W4,  1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, SQ,  W4,  1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, IDL, W4,  1'b0, 6'b10_10_00);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, NSQ, SGL, 1'b0, 6'b10_10_10);
    // S5: INCR with continuous SEQ; B releases after the 4th beat
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, IDL, SGL, 1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NSQ, INC, 1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, SQ,  INC, 1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, SQ,  INC, 1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, SQ,  INC, 1'b0, 6'b00_10_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, SQ,  INC, 1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, BSY, INC, 1'b0, 6'b00_10_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, IDL, INC, 1'b0, 6'b10_00_00);
    // S6: locked sequence of three transfers with HSELM=0 between them
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, IDL, SGL, 1'b0, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NSQ, SGL, 1'b1, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, IDL, SGL, 1'b1, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NSQ, SGL, 1'b1, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, IDL, SGL, 1'b1, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NSQ, SGL, 1'b1, 6'b00_00_00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, IDL, SGL, 1'b0, 6'b10_10_00);

    for (int i = 0; i < n_vec; i++) begin
      if (tbl[i].rst) begin
        do_reset($sformatf("reset before v%0d", i));
      end
      @(negedge HCLK);
      req_port0  = tbl[i].r0;
      req_port1  = tbl[i].r1;
      HREADYM    = tbl[i].rdy;
      HSELM      = tbl[i].sel;
      HTRANSM    = tbl[i].tr;
      HBURSTM    = tbl[i].bu;
      HMASTLOCKM = tbl[i].lk;
      @(posedge HCLK);
      #1;
      check_all($sformatf("v%0d", i), tbl[i].exp);
    end

    // Asynchronous reset in the middle of a locked sequence owned by port 1.
    do_reset("hs reset");
    @(negedge HCLK);
    req_port1 = 1'b1;
    @(posedge HCLK);
    #1;
    check_all("hs grant1", 6'b10_10_10);
    @(negedge HCLK);
    HSELM = 1'b1; HTRANSM = NSQ; HMASTLOCKM = 1'b1;
    @(posedge HCLK);
    #1;
    check_all("hs lock", 6'b10_10_10);
    @(negedge HCLK);
    req_port0 = 1'b1; HSELM = 1'b0; HTRANSM = IDL;
    @(posedge HCLK);
    #1;
    check_all("hs lock hold", 6'b10_10_10);
    #3;
    HREADYM = 1'b0;
    HRESETn = 1'b0;
    #1;
    check_all("hs async reset", 6'b01_01_01);
    @(posedge HCLK);
    #1;
    check_all("hs reset held", 6'b01_01_01);
    @(negedge HCLK);
    drive_idle();
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
